// File: rtl/micro_alpha_veryl_rr_mux.sv
// N-input registered mux with valid/ready handshakes and round-robin arbitration.
// Define MICRO_ALPHA_VERYL_RR_MUX_FIXED_PRIORITY_EN for fixed lowest-index-wins priority.
module micro_alpha_veryl_rr_mux #(
    parameter int unsigned N      = 2,
    parameter int unsigned WIDTH  = 32,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din [0:N-1],
    input  logic [N-1:0]     din_valid,
    output logic [N-1:0]     din_ready,
    output logic [WIDTH-1:0] dout,
    output logic [SEL_W-1:0] dout_sel,
    output logic             dout_valid,
    input  logic             dout_ready
);

    logic             load;
    logic             found;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] scan_base;
    int unsigned      scan_idx;

`ifdef MICRO_ALPHA_VERYL_RR_MUX_FIXED_PRIORITY_EN
    assign scan_base = '0;
`else
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;

    assign scan_base = ptr_q;
`endif

    // Output register is empty or being drained this cycle.
    assign load = !dout_valid || dout_ready;

    // Scan from scan_base with wrap; the first requester wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = 32'(scan_base) + k;
            if (scan_idx >= N) begin
                scan_idx = scan_idx - N;
            end
            if (!found && din_valid[scan_idx[SEL_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = scan_idx[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        din_ready = '0;
        if (found && load && !rst) begin
            din_ready[grant_idx] = 1'b1;
        end
    end

`ifndef MICRO_ALPHA_VERYL_RR_MUX_FIXED_PRIORITY_EN
    always_comb begin
        ptr_d = ptr_q;
        if (load && found) begin
            ptr_d = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_sel   <= '0;
            dout_valid <= 1'b0;
        end else if (load) begin
            if (found) begin
                dout       <= din[grant_idx];
                dout_sel   <= grant_idx;
                dout_valid <= 1'b1;
            end else begin
                // Nothing to forward: drop valid but keep the last word visible.
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_micro_alpha_veryl_rr_mux.sv
// Self-checking bench for micro_alpha_veryl_rr_mux (N=4): directed scenarios plus a
// randomized run against a queue-free behavioural arbiter model.
module tb_micro_alpha_veryl_rr_mux;

    localparam int unsigned N     = 4;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] din [0:N-1];
    logic [N-1:0]     din_valid;
    logic [N-1:0]     din_ready;
    logic [WIDTH-1:0] dout;
    logic [SEL_W-1:0] dout_sel;
    logic             dout_valid;
    logic             dout_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    int               m_ptr   = 0;
    logic [WIDTH-1:0] m_dout  = '0;
    int               m_sel   = 0;
    bit               m_valid = 1'b0;

    micro_alpha_veryl_rr_mux #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_sel   (dout_sel),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    function automatic int m_grant();
        int start;
`ifdef MICRO_ALPHA_VERYL_RR_MUX_FIXED_PRIORITY_EN
        start = 0;
`else
        start = m_ptr;
`endif
        for (int k = 0; k < N; k++) begin
            if (din_valid[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = m_grant();
        if (!rst && (!m_valid || dout_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Advance one clock: update the model from the inputs in force at the edge.
    task automatic tick();
        int g;
        bit ld;
        g  = m_grant();
        ld = !m_valid || dout_ready;
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_dout = '0; m_sel = 0; m_valid = 1'b0;
        end else if (ld) begin
            if (g >= 0) begin
                m_dout  = din[g];
                m_sel   = g;
                m_valid = 1'b1;
                m_ptr   = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        din_valid  = '1;
        dout_ready = 1'b1;
        for (int i = 0; i < N; i++) din[i] = 32'hDEAD_0000 + i;
        tick();
        #1;
        n_tests++;
        if (din_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_din_ready: got %b expected 0", din_ready);
        end
        tick();
        n_tests++;
        if (dout_valid !== 1'b0 || dout !== '0 || dout_sel !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b d=%h s=%0d expected v=0 d=0 s=0",
                     dout_valid, dout, dout_sel);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        din[0]     = 32'hA5A5;
        din_valid  = 4'b0001;
        dout_ready = 1'b1;
        #1;
        n_tests++;
        if (din_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL basic_ready: got %b expected 0001", din_ready);
        end
        tick();
        n_tests++;
        if (dout !== 32'hA5A5 || dout_sel !== 2'd0 || dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_out: got d=%h s=%0d v=%b expected d=a5a5 s=0 v=1",
                     dout, dout_sel, dout_valid);
        end
    endtask

    task automatic test_backpressure();
        din[1]     = 32'h5A5A;
        din_valid  = 4'b0010;
        dout_ready = 1'b1;
        tick();
        din_valid  = 4'b0011;
        dout_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_tests++;
            if (din_ready !== '0) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: got %b expected 0000", c, din_ready);
            end
            tick();
            n_tests++;
            if (dout !== 32'h5A5A || dout_sel !== 2'd1 || dout_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got d=%h s=%0d v=%b expected d=5a5a s=1 v=1",
                         c, dout, dout_sel, dout_valid);
            end
        end
        dout_ready = 1'b1;
        #1;
        n_tests++;
        if (din_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b expected 0001", din_ready);
        end
        tick();
        n_tests++;
        if (dout_sel !== 2'd0 || dout !== din[0]) begin
            n_fail++;
            $display("FAIL bp_release_out: got s=%0d d=%h expected s=0 d=%h",
                     dout_sel, dout, din[0]);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        for (int i = 0; i < N; i++) din[i] = 32'h10 + i;
        din_valid  = '1;
        dout_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_tests++;
            if (dout_sel !== SEL_W'(c % 4) || dout !== 32'(32'h10 + c % 4)
                || dout_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rotation[%0d]: got s=%0d d=%h v=%b expected s=%0d d=%h v=1",
                         c, dout_sel, dout, dout_valid, c % 4, 32'h10 + c % 4);
            end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        for (int i = 0; i < N; i++) din[i] = 32'h10 + i;
        din_valid  = '1;
        dout_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_tests++;
            if (din_ready !== 4'b0001) begin
                n_fail++;
                $display("FAIL fixed_ready[%0d]: got %b expected 0001", c, din_ready);
            end
            tick();
            n_tests++;
            if (dout_sel !== 2'd0 || dout !== 32'h10) begin
                n_fail++;
                $display("FAIL fixed_out[%0d]: got s=%0d d=%h expected s=0 d=10",
                         c, dout_sel, dout);
            end
        end
    endtask

    task automatic test_idle_drain();
        din[2]     = 32'hCAFE_0002;
        din_valid  = 4'b0100;
        dout_ready = 1'b1;
        tick();
        din_valid = '0;
        tick();
        n_tests++;
        if (dout_valid !== 1'b0 || dout !== 32'hCAFE_0002 || dout_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL idle_drain: got v=%b d=%h s=%0d expected v=0 d=cafe0002 s=2",
                     dout_valid, dout, dout_sel);
        end
    endtask

    task automatic test_mid_reset();
        din[3]     = 32'h0BAD_F00D;
        din_valid  = 4'b1000;
        dout_ready = 1'b0;
        tick();
        n_tests++;
        if (dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_setup: got v=%b expected 1", dout_valid);
        end
        rst       = 1'b1;
        din_valid = 4'b0011;
        #1;
        n_tests++;
        if (din_ready !== '0) begin
            n_fail++;
            $display("FAIL midrst_ready: got %b expected 0000", din_ready);
        end
        tick();
        rst = 1'b0;
        n_tests++;
        if (dout_valid !== 1'b0 || dout !== '0 || dout_sel !== '0) begin
            n_fail++;
            $display("FAIL midrst_state: got v=%b d=%h s=%0d expected v=0 d=0 s=0",
                     dout_valid, dout, dout_sel);
        end
        dout_ready = 1'b1;
        #1;
        n_tests++;
        if (din_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrst_first_grant: got %b expected 0001", din_ready);
        end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] exp_ready;
        for (int c = 0; c < 600; c++) begin
            exp_ready = m_ready();
            #1;
            n_tests++;
            if (din_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", c, din_ready, exp_ready);
            end
            tick();
            n_tests++;
            if (dout_valid !== m_valid || dout !== m_dout || dout_sel !== SEL_W'(m_sel)) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h s=%0d expected v=%b d=%h s=%0d",
                         c, dout_valid, dout, dout_sel, m_valid, m_dout, m_sel);
            end
            // Requesters hold until accepted, then may issue a new word.
            for (int i = 0; i < N; i++) begin
                if (!din_valid[i] || exp_ready[i]) begin
                    din_valid[i] = 1'($urandom_range(0, 1));
                    din[i]       = $urandom;
                end
            end
            dout_ready = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 49) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        din_valid  = '0;
        dout_ready = 1'b0;
        for (int i = 0; i < N; i++) din[i] = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
`ifdef MICRO_ALPHA_VERYL_RR_MUX_FIXED_PRIORITY_EN
        test_fixed_priority();
`else
        test_rotation();
`endif
        test_idle_drain();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
